// File: rtl/nand_op_sequencer.sv
// Time-multiplexes one data_width-bit NAND unit to evaluate eight bitwise logic ops.
// Each op is a fixed chain of NAND steps, one per clock, with valid/ready at both ends.
module nand_op_sequencer #(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] y,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {S_A, S_B, S_T, S_U, S_Y} src_t;
  typedef enum logic [1:0] {D_T, D_U, D_Y} dst_t;

  localparam logic [2:0] OP_NAND = 3'b000, OP_AND = 3'b001, OP_OR  = 3'b010, OP_NOR = 3'b011,
                         OP_XOR  = 3'b100, OP_XNOR = 3'b101, OP_NOT = 3'b110, OP_BUF = 3'b111;

  state_t                state;
  logic [2:0]            op_r, step;
  logic [data_width-1:0] a_r, b_r, t_r, u_r;
  src_t                  sel_x, sel_z;
  dst_t                  dst;
  logic                  last;
  logic [data_width-1:0] opnd_x, opnd_z, nand_q;

  // Per-op micro-sequence: two operand selects, a destination and the final-step flag.
  always_comb begin
    sel_x = S_A;
    sel_z = S_B;
    dst   = D_Y;
    last  = 1'b1;
    case (op_r)
      OP_AND, OP_BUF: begin
        if (step == 3'd0) begin
          sel_z = (op_r == OP_BUF) ? S_A : S_B;
          dst   = D_T;
          last  = 1'b0;
        end else begin
          sel_x = S_T;
          sel_z = S_T;
        end
      end
      OP_OR, OP_NOR: begin
        case (step)
          3'd0:    begin sel_z = S_A; dst = D_T; last = 1'b0; end
          3'd1:    begin sel_x = S_B; dst = D_U; last = 1'b0; end
          3'd2:    begin sel_x = S_T; sel_z = S_U; last = (op_r == OP_OR); end
          default: begin sel_x = S_Y; sel_z = S_Y; end
        endcase
      end
      OP_XOR, OP_XNOR: begin
        case (step)
          3'd0:    begin dst = D_T; last = 1'b0; end
          3'd1:    begin sel_z = S_T; dst = D_U; last = 1'b0; end
          3'd2:    begin sel_x = S_B; sel_z = S_T; dst = D_T; last = 1'b0; end
          3'd3:    begin sel_x = S_U; sel_z = S_T; last = (op_r == OP_XOR); end
          default: begin sel_x = S_Y; sel_z = S_Y; end
        endcase
      end
      OP_NOT:  sel_z = S_A;
      default: ;
    endcase
  end

  function automatic logic [data_width-1:0] pick(input src_t s, input logic [data_width-1:0] va,
      input logic [data_width-1:0] vb, input logic [data_width-1:0] vt,
      input logic [data_width-1:0] vu, input logic [data_width-1:0] vy);
    case (s)
      S_A:     pick = va;
      S_B:     pick = vb;
      S_T:     pick = vt;
      S_U:     pick = vu;
      default: pick = vy;
    endcase
  endfunction

  assign opnd_x = pick(sel_x, a_r, b_r, t_r, u_r, y);
  assign opnd_z = pick(sel_z, a_r, b_r, t_r, u_r, y);
  assign nand_q = ~(opnd_x & opnd_z);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      t_r       <= '0;
      u_r       <= '0;
      y         <= '0;
      step      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r     <= op;
          a_r      <= a;
          b_r      <= b;
          step     <= '0;
          state    <= EXEC;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        EXEC: begin
          case (dst)
            D_T:     t_r <= nand_q;
            D_U:     u_r <= nand_q;
            default: y   <= nand_q;
          endcase
          if (last) begin
            state     <= DONE;
            step      <= '0;
            out_valid <= 1'b1;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer: driver queues hand-computed results,
// a negedge monitor checks every result handshake and the valid-rise latency.
module tb_nand_op_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       busy;

  nand_op_sequencer #(.data_width(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] y; int lat; } exp_t;
  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0, failures = 0;

  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: acceptance times, latency on out_valid rise, result on handshake.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        acc_q.delete();
        prev = 1'b0;
      end else begin
        if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        if (out_valid && !prev) begin
          if (sb.size() == 0 || acc_q.size() == 0) chk("spurious_valid", 1, 0);
          else chk("latency", cyc - acc_q.pop_front(), sb[0].lat);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = sb.pop_front();
            chk("y", y, e.y);
          end
        end
        prev = out_valid;
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] ey, input int lat);
    int n;
    sb.push_back('{ey, lat});
    op = o; a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_y"}, y, 8'h00);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [7:0] vec_y   [8] = '{8'hFA, 8'h05, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};
  int         vec_lat [8] = '{1, 2, 3, 4, 4, 5, 1, 2};

  initial begin
    int t0, t1, n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    idle_checks("por");

    // Reset while a result is parked in DONE.
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'b001, 8'hA5, 8'h0F, 8'h05, 2);
    wait_valid();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    idle_checks("rst_done");
    @(posedge clk); #1 out_ready = 1'b1;

    // Every op on the same operands.
    for (int i = 0; i < 8; i++) send(3'(i), 8'hA5, 8'h0F, vec_y[i], vec_lat[i]);
    wait_valid();
    @(posedge clk); #1;

    // Stalled consumer: result must hold and no new request may slip in.
    out_ready = 1'b0;
    send(3'b100, 8'hF0, 8'h3C, 8'hCC, 4);
    wait_valid();
    op = 3'b110; a = 8'h0F; b = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_y", y, 8'hCC);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_in_ready", in_ready, 0);
    send(3'b110, 8'h0F, 8'h00, 8'hF0, 1);

    // Operands changed right after acceptance.
    send(3'b101, 8'h12, 8'h34, 8'hD9, 5);
    a = 8'hFF; b = 8'h00; op = 3'b000;

    // Abort XNOR on its third EXEC cycle.
    send(3'b101, 8'h12, 8'h34, 8'hD9, 5);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    idle_checks("rst_exec");
    @(posedge clk); #1;
    send(3'b000, 8'hFF, 8'h0F, 8'hF0, 1);

    // Back-to-back AND, consumer always ready: one accept every 4 cycles.
    send(3'b001, 8'hFF, 8'h81, 8'h81, 2);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      send(3'b001, 8'hFF, 8'h81, 8'h81, 2);
      t1 = cyc;
      chk("b2b_period", t1 - t0, 4);
      t0 = t1;
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
